// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - widths, constants and rounding helpers shared by the FP32 add back end
package fpu_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int SUM_W   = MAN_W + 5;
  localparam int NRM_W   = MAN_W + 4;
  localparam int EXPI_W  = EXP_W + 2;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam int RES_W        = 1 + EXP_W + MAN_W;
  localparam int RES_MAN_LSB  = 0;
  localparam int RES_EXP_LSB  = MAN_W;
  localparam int RES_SIGN_BIT = EXP_W + MAN_W;

  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RUP = 2'b10,
    RND_RDN = 2'b11
  } rnd_mode_t;

  function automatic logic round_inc(input rnd_mode_t mode, input logic sign,
                                     input logic lsb, input logic g,
                                     input logic r, input logic s);
    logic inc;
    case (mode)
      RND_RNE: inc = g & (r | s | lsb);
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = ~sign & (g | r | s);
      default: inc = sign & (g | r | s);
    endcase
    return inc;
  endfunction

  // Overflow goes to infinity only when the mode rounds towards it for this sign.
  function automatic logic ovf_to_inf(input rnd_mode_t mode, input logic sign);
    logic inf;
    case (mode)
      RND_RNE: inf = 1'b1;
      RND_RTZ: inf = 1'b0;
      RND_RUP: inf = ~sign;
      default: inf = sign;
    endcase
    return inf;
  endfunction

endpackage

// File: rtl/fpu_lzc27.sv
// rtl/fpu_lzc27.sv - combinational 27-bit leading-zero counter with all-zero flag
module fpu_lzc27 (
  input  logic [26:0] value,
  output logic [4:0]  count,
  output logic        zero
);

  // Scan upward so the highest set bit makes the last assignment.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

  assign zero = ~|value;

endmodule

// File: rtl/fpu_normalize_round.sv
// rtl/fpu_normalize_round.sv - 3-stage normalise/round/pack back end of the FP32 adder
// Optional FPU_NORM_ROUND_MODE_EN adds the rnd_mode input (RNE/RTZ/RUP/RDN); otherwise RNE only.
module fpu_normalize_round
  import fpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
`ifdef FPU_NORM_ROUND_MODE_EN
  input  logic [1:0]       rnd_mode,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_inexact
);

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  rnd_mode_t in_mode;
`ifdef FPU_NORM_ROUND_MODE_EN
  assign in_mode = rnd_mode_t'(rnd_mode);
`else
  assign in_mode = RND_RNE;
`endif

  // ---------------- S1: carry shift or leading-zero count ----------------
  logic [4:0] lzc_count;
  logic       lzc_zero;
  logic       carry;

  assign carry = in_sum[SUM_W-1];

  fpu_lzc27 u_lzc (
    .value (in_sum[NRM_W-1:0]),
    .count (lzc_count),
    .zero  (lzc_zero)
  );

  logic                     s1_valid;
  logic                     s1_sign;
  logic                     s1_zero;
  rnd_mode_t                s1_mode;
  logic signed [EXPI_W-1:0] s1_exp;
  logic [4:0]               s1_lzc;
  logic [NRM_W-1:0]         s1_mant;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_sign  <= in_sign;
      s1_zero  <= lzc_zero & ~carry;
      s1_mode  <= in_mode;
      if (carry) begin
        // The bit shifted out joins the sticky bit.
        s1_mant <= {in_sum[SUM_W-1:2], in_sum[1] | in_sum[0]};
        s1_exp  <= $signed({2'b00, in_exp}) + 10'sd1;
        s1_lzc  <= 5'd0;
      end else begin
        s1_mant <= in_sum[NRM_W-1:0];
        s1_exp  <= $signed({2'b00, in_exp});
        s1_lzc  <= lzc_count;
      end
    end
  end

  // ---------------- S2: left shift, exponent adjust, flush detect ----------------
  logic [NRM_W-1:0]         s2_mant_d;
  logic signed [EXPI_W-1:0] s2_exp_d;
  logic                     s2_unf_d;

  assign s2_mant_d = s1_mant << s1_lzc;
  assign s2_exp_d  = s1_exp - $signed({{(EXPI_W-5){1'b0}}, s1_lzc});
  assign s2_unf_d  = ~s1_zero & (s2_exp_d[EXPI_W-1] | (s2_exp_d == '0));

  logic                     s2_valid;
  logic                     s2_sign;
  logic                     s2_zero;
  logic                     s2_unf;
  rnd_mode_t                s2_mode;
  logic signed [EXPI_W-1:0] s2_exp;
  logic [NRM_W-1:0]         s2_mant;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_unf   <= s2_unf_d;
      s2_mode  <= s1_mode;
      s2_exp   <= s2_exp_d;
      s2_mant  <= s2_mant_d;
    end
  end

  // ---------------- S3: round, range check, pack ----------------
  logic [MAN_W:0]           s3_sig;
  logic                     s3_g, s3_r, s3_s;
  logic                     s3_inc;
  logic [MAN_W+1:0]         s3_rnd;
  logic signed [EXPI_W-1:0] s3_exp;
  logic                     s3_ovf;

  assign s3_sig = s2_mant[NRM_W-1:3];
  assign s3_g   = s2_mant[2];
  assign s3_r   = s2_mant[1];
  assign s3_s   = s2_mant[0];
  assign s3_inc = round_inc(s2_mode, s2_sign, s3_sig[0], s3_g, s3_r, s3_s);
  assign s3_rnd = {1'b0, s3_sig} + {{(MAN_W+1){1'b0}}, s3_inc};
  // Carry-out of the significand leaves the fraction all zero; bump the exponent.
  assign s3_exp = s2_exp + $signed({{(EXPI_W-1){1'b0}}, s3_rnd[MAN_W+1]});
  assign s3_ovf = ~s2_zero & ~s2_unf & (s3_exp >= EXP_MAX);

  logic [RES_W-1:0] res_d;
  logic             ovf_d, unf_d, inex_d;

  always_comb begin
    res_d  = '0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    inex_d = s3_g | s3_r | s3_s;
    if (s2_zero) begin
      res_d[RES_SIGN_BIT] = (s2_mode == RND_RDN);
      inex_d              = 1'b0;
    end else if (s2_unf) begin
      res_d[RES_SIGN_BIT] = s2_sign;
      unf_d               = 1'b1;
      inex_d              = 1'b1;
    end else if (s3_ovf) begin
      ovf_d  = 1'b1;
      inex_d = 1'b1;
      res_d[RES_SIGN_BIT] = s2_sign;
      if (ovf_to_inf(s2_mode, s2_sign)) begin
        res_d[RES_EXP_LSB +: EXP_W] = '1;
      end else begin
        res_d[RES_EXP_LSB +: EXP_W] = EXP_W'(EXP_MAX - 1);
        res_d[RES_MAN_LSB +: MAN_W] = '1;
      end
    end else begin
      res_d[RES_SIGN_BIT]         = s2_sign;
      res_d[RES_EXP_LSB +: EXP_W] = s3_exp[EXP_W-1:0];
      res_d[RES_MAN_LSB +: MAN_W] = s3_rnd[MAN_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_result  <= res_d;
        out_ovf     <= ovf_d;
        out_unf     <= unf_d;
        out_inexact <= inex_d;
      end
    end
  end

endmodule

// File: tb/tb_fpu_normalize_round.sv
// tb/tb_fpu_normalize_round.sv - directed self-checking bench for fpu_normalize_round
module tb_fpu_normalize_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [27:0] in_sum = 28'd0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_ovf, out_unf, out_inexact;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fpu_normalize_round dut (
    .clk         (clk),
    .rst         (rst),
`ifdef FPU_NORM_ROUND_MODE_EN
    .rnd_mode    (2'b00),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_sum      (in_sum),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
  );

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] sum;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inex;
  } vec_t;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid);
    else passes++;
    checks++;
    if ({out_result, out_ovf, out_unf, out_inexact} !== 35'd0)
      $display("FAIL reset_outputs: got %h %b%b%b expected 0", out_result, out_ovf, out_unf, out_inexact);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else passes++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int n;
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_sum = 28'h800_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 3) $display("FAIL latency: got %0d cycles expected 3", n);
    else passes++;
    checks++;
    if ({out_result, out_ovf, out_unf, out_inexact} !== {32'h4000_0000, 3'b000})
      $display("FAIL one_plus_one: got %h %b%b%b expected 40000000 000", out_result, out_ovf, out_unf, out_inexact);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    vec_t v[$];
    int   n;
    v.push_back('{"one_plus_one",   1'b0, 8'd127, 28'h800_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0});
    v.push_back('{"cancel_lzc23",   1'b0, 8'd127, 28'h000_0008, 32'h3400_0000, 1'b0, 1'b0, 1'b0});
    v.push_back('{"rne_tie_even",   1'b0, 8'd127, 28'h400_0004, 32'h3F80_0000, 1'b0, 1'b0, 1'b1});
    v.push_back('{"rne_tie_odd",    1'b0, 8'd127, 28'h400_000C, 32'h3F80_0002, 1'b0, 1'b0, 1'b1});
    v.push_back('{"round_carry",    1'b0, 8'd127, 28'h7FF_FFFC, 32'h4000_0000, 1'b0, 1'b0, 1'b1});
    v.push_back('{"overflow",       1'b0, 8'd254, 28'h800_0000, 32'h7F80_0000, 1'b1, 1'b0, 1'b1});
    v.push_back('{"round_ovf",      1'b0, 8'd254, 28'h7FF_FFFC, 32'h7F80_0000, 1'b1, 1'b0, 1'b1});
    v.push_back('{"max_finite",     1'b0, 8'd254, 28'h7FF_FFF8, 32'h7F7F_FFFF, 1'b0, 1'b0, 1'b0});
    v.push_back('{"underflow",      1'b0, 8'd10,  28'h000_0008, 32'h0000_0000, 1'b0, 1'b1, 1'b1});
    v.push_back('{"underflow_neg",  1'b1, 8'd10,  28'h000_0008, 32'h8000_0000, 1'b0, 1'b1, 1'b1});
    v.push_back('{"exp_adj_zero",   1'b0, 8'd23,  28'h000_0008, 32'h0000_0000, 1'b0, 1'b1, 1'b1});
    v.push_back('{"exp_adj_one",    1'b0, 8'd24,  28'h000_0008, 32'h0080_0000, 1'b0, 1'b0, 1'b0});
    v.push_back('{"exact_zero",     1'b1, 8'd127, 28'h000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0});
    v.push_back('{"carry_sticky",   1'b0, 8'd127, 28'h800_0003, 32'h4000_0000, 1'b0, 1'b0, 1'b1});
    v.push_back('{"carry_round",    1'b0, 8'd127, 28'h800_0018, 32'h4000_0002, 1'b0, 1'b0, 1'b1});
    v.push_back('{"negative_one",   1'b1, 8'd127, 28'h400_0000, 32'hBF80_0000, 1'b0, 1'b0, 1'b0});
    out_ready = 1'b1;
    foreach (v[k]) begin
      in_valid = 1'b1; in_sign = v[k].sign; in_exp = v[k].exp; in_sum = v[k].sum;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (out_valid !== 1'b1 ||
          {out_result, out_ovf, out_unf, out_inexact} !== {v[k].res, v[k].ovf, v[k].unf, v[k].inex})
        $display("FAIL %s: got valid=%b %h ovf=%b unf=%b inex=%b expected %h ovf=%b unf=%b inex=%b",
                 v[k].name, out_valid, out_result, out_ovf, out_unf, out_inexact,
                 v[k].res, v[k].ovf, v[k].unf, v[k].inex);
      else passes++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] exp_q [4];
    int sent, got, cyc, stall_left;
    logic seen;
    exp_q[0] = 32'h3C00_0000;
    exp_q[1] = 32'h3C80_0000;
    exp_q[2] = 32'h3D00_0000;
    exp_q[3] = 32'h3D80_0000;
    sent = 0; got = 0; cyc = 0; stall_left = 2;
    while (got < 4 && cyc < 40) begin
      in_valid  = (sent < 4);
      in_sign   = 1'b0;
      in_exp    = 8'(120 + sent);
      in_sum    = 28'h400_0000;
      out_ready = !(out_valid && stall_left > 0);
      #1;
      if (!out_ready) begin
        stall_left--;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        else passes++;
        checks++;
        if (out_result !== exp_q[got]) $display("FAIL stall_hold: got %h expected %h", out_result, exp_q[got]);
        else passes++;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checks++;
        if (out_result !== exp_q[got]) $display("FAIL b2b_beat%0d: got %h expected %h", got, out_result, exp_q[got]);
        else passes++;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got !== 4 || sent !== 4) $display("FAIL b2b_count: got %0d out %0d in expected 4 4", got, sent);
    else passes++;
    seen = 1'b0;
    repeat (4) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL b2b_duplicate: got extra out_valid expected none");
    else passes++;
  endtask

  task automatic test_reset_midstream();
    int   n;
    logic seen;
    out_ready = 1'b1;
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd100; in_sum = 28'h400_0000;
    @(posedge clk); #1;
    in_exp = 8'd101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h3200_0000)
      $display("FAIL pre_reset_beat: got valid=%b %h expected 1 32000000", out_valid, out_result);
    else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0)
      $display("FAIL midreset_clear: got valid=%b %h expected 0 00000000", out_valid, out_result);
    else passes++;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL midreset_discard: got stale out_valid expected none");
    else passes++;
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'd130; in_sum = 28'h400_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 3 || out_result !== 32'hC100_0000)
      $display("FAIL post_reset_beat: got %0d cycles %h expected 3 c1000000", n, out_result);
    else passes++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back_stall();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
